// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
// Read owner encoding, CPU FSM states and bus widths.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } cpu_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of CPU, video and RAM-side signals around the arbiter.
// slave = arbiter view, master = requesters and RAM view.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter for one requester.
// sat_o flags that the requester must now be served.
module arb_wait_counter
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    assign sat_o = (cnt_q >= MAX_C);

    // Clear wins over increment; hold once saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between CPU and video scanout.
// Optional RAM_ARBITER_STATS_EN adds stall/override statistics ports.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    ram_arbiter_if.slave bus
`ifdef RAM_ARBITER_STATS_EN
    ,
    output logic [31:0] stat_cpu_stall_cnt,
    output logic [15:0] stat_vid_override_cnt
`endif
);

    cpu_state_e state_q, state_d;
    owner_e     rd_owner_q, rd_owner_d;

    logic              cpu_elig;
    logic              cpu_win;
    logic              vid_win;
    logic              vid_sat;
    logic              cpu_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_vid_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (bus.vid_req && !vid_win),
        .clr_i   (vid_win || !bus.vid_req),
        .sat_o   (vid_sat)
    );

    // Grant, RAM mux and next-state; outputs forced idle while in reset
    always_comb begin
        state_d    = state_q;
        rd_owner_d = OWN_NONE;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;

        cpu_elig = (state_q == ST_IDLE);
        vid_win  = reset_n && bus.vid_req &&
                   (!cpu_elig || !bus.cpu_req || vid_sat);
        cpu_win  = reset_n && cpu_elig && bus.cpu_req && !vid_win;

        unique case (1'b1)
            cpu_win: begin
                ram_addr  = bus.cpu_addr;
                ram_we    = bus.cpu_we;
                ram_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
                if (!bus.cpu_we) begin
                    state_d    = ST_RD_WAIT;
                    rd_owner_d = OWN_CPU;
                end
            end
            vid_win: begin
                ram_addr   = bus.vid_addr;
                rd_owner_d = OWN_VID;
            end
            default: ;
        endcase

        if (state_q == ST_RD_WAIT) begin
            state_d = ST_IDLE;
        end

        cpu_ack = (cpu_win && bus.cpu_we) || (state_q == ST_RD_WAIT);
    end

    // CPU state and read-owner registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Drive the bus from the arbitration result and read-return owner
    always_comb begin
        bus.ram_addr   = ram_addr;
        bus.ram_we     = ram_we;
        bus.ram_wdata  = ram_wdata;
        bus.cpu_ack    = cpu_ack;
        bus.cpu_stall  = bus.cpu_req && !cpu_ack;
        bus.cpu_rdata  = (state_q == ST_RD_WAIT) ? bus.ram_rdata : '0;
        bus.vid_gnt    = vid_win;
        bus.vid_rvalid = (rd_owner_q == OWN_VID);
        bus.vid_rdata  = (rd_owner_q == OWN_VID) ? bus.ram_rdata : '0;
    end

`ifdef RAM_ARBITER_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] ovr_cnt_q;

    // Wrapping counters of CPU stall cycles and starvation overrides
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            if (bus.cpu_req && !cpu_ack) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (vid_win && vid_sat && cpu_elig && bus.cpu_req) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    assign stat_cpu_stall_cnt    = stall_cnt_q;
    assign stat_vid_override_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle RAM.
// Define RAM_ARBITER_STATS_EN to also check the statistics ports.
module tb_ram_arbiter;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   n_stall_obs;

    logic [15:0] mem [0:32767];

    ram_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

`ifdef RAM_ARBITER_STATS_EN
    logic [31:0] stat_cpu_stall_cnt;
    logic [15:0] stat_vid_override_cnt;
`endif

    ram_arbiter #(
        .ADDR_W   (15),
        .DATA_W   (16),
        .MAX_WAIT (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef RAM_ARBITER_STATS_EN
        ,
        .stat_cpu_stall_cnt    (stat_cpu_stall_cnt),
        .stat_vid_override_cnt (stat_vid_override_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Independent count of stall cycles seen on the bus
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) n_stall_obs <= 0;
        else if (bus.cpu_stall) n_stall_obs <= n_stall_obs + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // CPU writes back to back while video waits on 0x4002
    task automatic starve(input int run);
        bus.vid_req  = 1'b1;
        bus.vid_addr = 15'h4002;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_addr  = 15'(32'h20 + i);
            bus.cpu_wdata = 16'(32'h100 * run + i);
            #1;
            check($sformatf("starve%0d_deny%0d_gnt", run, i),
                  32'(bus.vid_gnt), 32'd0);
            check($sformatf("starve%0d_deny%0d_ack", run, i),
                  32'(bus.cpu_ack), 32'd1);
            next();
        end
        #1;
        check($sformatf("starve%0d_ovr_gnt", run), 32'(bus.vid_gnt), 32'd1);
        check($sformatf("starve%0d_ovr_stall", run), 32'(bus.cpu_stall), 32'd1);
        check($sformatf("starve%0d_ovr_we", run), 32'(bus.ram_we), 32'd0);
        check($sformatf("starve%0d_ovr_addr", run), 32'(bus.ram_addr), 32'h4002);
        next();
        #1;
        check($sformatf("starve%0d_after_gnt", run), 32'(bus.vid_gnt), 32'd0);
        check($sformatf("starve%0d_after_ack", run), 32'(bus.cpu_ack), 32'd1);
        check($sformatf("starve%0d_rvalid", run), 32'(bus.vid_rvalid), 32'd1);
        check($sformatf("starve%0d_rdata", run), 32'(bus.vid_rdata), 32'h7777);
        next();
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        next();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int a = 0; a < 32768; a++) mem[a] = 16'h0000;
        mem[15'h4000] = 16'h1234;
        mem[15'h0001] = 16'hAAAA;
        mem[15'h4001] = 16'h5555;
        mem[15'h4002] = 16'h7777;

        reset_n       = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_vid_gnt", 32'(bus.vid_gnt), 32'd0);
        check("rst_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        reset_n = 1'b1;
        next();

        // CPU write 0xBEEF to 0x0010
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 15'h0010;
        bus.cpu_wdata = 16'hBEEF;
        #1;
        check("wr_ram_we", 32'(bus.ram_we), 32'd1);
        check("wr_ack", 32'(bus.cpu_ack), 32'd1);
        check("wr_stall", 32'(bus.cpu_stall), 32'd0);
        check("wr_addr", 32'(bus.ram_addr), 32'h0010);
        check("wr_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        next();

        // CPU read back 0x0010: one stall cycle then data
        bus.cpu_we = 1'b0;
        #1;
        check("rd_issue_ack", 32'(bus.cpu_ack), 32'd0);
        check("rd_issue_stall", 32'(bus.cpu_stall), 32'd1);
        check("rd_issue_we", 32'(bus.ram_we), 32'd0);
        next();
        #1;
        check("rd_wait_ack", 32'(bus.cpu_ack), 32'd1);
        check("rd_wait_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
        check("rd_wait_stall", 32'(bus.cpu_stall), 32'd0);
        next();
        bus.cpu_req = 1'b0;

        // Video alone reads 0x4000
        bus.vid_req  = 1'b1;
        bus.vid_addr = 15'h4000;
        #1;
        check("vid_gnt", 32'(bus.vid_gnt), 32'd1);
        check("vid_addr", 32'(bus.ram_addr), 32'h4000);
        check("vid_gnt_rvalid", 32'(bus.vid_rvalid), 32'd0);
        next();
        bus.vid_req = 1'b0;
        #1;
        check("vid_rvalid", 32'(bus.vid_rvalid), 32'd1);
        check("vid_rdata", 32'(bus.vid_rdata), 32'h1234);
        next();
        #1;
        check("vid_rvalid_once", 32'(bus.vid_rvalid), 32'd0);

        starve(1);
        starve(2);
`ifdef RAM_ARBITER_STATS_EN
        #1;
        check("stat_override", 32'(stat_vid_override_cnt), 32'd2);
        check("stat_stall", stat_cpu_stall_cnt, 32'(n_stall_obs));
`endif

        // CPU read 0x0001 with video 0x4001 pending: pipelined
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'h0001;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 15'h4001;
        #1;
        check("pipe_n_gnt", 32'(bus.vid_gnt), 32'd0);
        check("pipe_n_addr", 32'(bus.ram_addr), 32'h0001);
        check("pipe_n_stall", 32'(bus.cpu_stall), 32'd1);
        next();
        #1;
        check("pipe_n1_gnt", 32'(bus.vid_gnt), 32'd1);
        check("pipe_n1_addr", 32'(bus.ram_addr), 32'h4001);
        check("pipe_n1_ack", 32'(bus.cpu_ack), 32'd1);
        check("pipe_n1_rdata", 32'(bus.cpu_rdata), 32'hAAAA);
        next();
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        #1;
        check("pipe_n2_rvalid", 32'(bus.vid_rvalid), 32'd1);
        check("pipe_n2_rdata", 32'(bus.vid_rdata), 32'h5555);
        check("pipe_n2_ack", 32'(bus.cpu_ack), 32'd0);
        next();

        // Reset asserted during CPU RD_WAIT with video granted
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'h0010;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 15'h4000;
        next();
        #1;
        check("rstw_pre_ack", 32'(bus.cpu_ack), 32'd1);
        check("rstw_pre_gnt", 32'(bus.vid_gnt), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstw_ack", 32'(bus.cpu_ack), 32'd0);
        check("rstw_gnt", 32'(bus.vid_gnt), 32'd0);
        check("rstw_ram_we", 32'(bus.ram_we), 32'd0);
        check("rstw_rvalid", 32'(bus.vid_rvalid), 32'd0);
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        next();
        next();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next();
            #1;
            check($sformatf("post_rst%0d_ack", i), 32'(bus.cpu_ack), 32'd0);
            check($sformatf("post_rst%0d_rvalid", i),
                  32'(bus.vid_rvalid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters:
  - the Hack CPU's load/store path (address, write strobe, write data);
  - the video scanout reader that fetches the screen map.
- Arbitrates every cycle and tracks the owner of each in-flight read.
- Returns read data to the correct requester one cycle after issue.
- Generates a stall for the CPU clock-enable; a starvation counter guarantees video a bounded wait.

Parameters:
- ADDR_W, 15, RAM word-address width.
- DATA_W, 16, RAM data width.
- MAX_WAIT, 4, cycles video may be denied before it overrides CPU priority (legal range 1..15).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests a RAM access; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  access complete; read data valid this cycle.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack && !cpu_we.
- cpu_stall  out  1  cpu_req && !cpu_ack.
- vid_req  in  1  video read request; held until vid_gnt.
- vid_addr  in  ADDR_W  video word address.
- vid_gnt  out  1  video request accepted this cycle.
- vid_rvalid  out  1  video read data valid (cycle after vid_gnt).
- vid_rdata  out  DATA_W  video read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM synchronous read data (1-cycle latency).

Behaviour:
- Reset (async assert, sync deassert in the system):
  - rd_owner=NONE, cpu_state=IDLE, wait_cnt=0.
  - All outputs 0: cpu_ack, vid_gnt, vid_rvalid, ram_we; ram_addr=0, ram_wdata=0.
  - Any in-flight read is dropped; no ack or rvalid follows.
- CPU FSM:
  - IDLE: CPU wins on cpu_req when (!vid_req || wait_cnt<MAX_WAIT).
    - Write: ram_we=1 and cpu_ack=1 in the same cycle; stay IDLE.
    - Read: issue read, go to RD_WAIT, cpu_ack=0.
  - RD_WAIT (one cycle):
    - cpu_ack=1, cpu_rdata=ram_rdata; go to IDLE.
    - The held cpu_req is not re-issued in this cycle.
- Grant logic (combinational from the current state):
  - CPU is eligible only in IDLE.
  - Video wins if vid_req && (CPU not eligible || !cpu_req || wait_cnt>=MAX_WAIT).
  - Exactly one winner drives ram_addr/ram_we/ram_wdata; with no winner, ram_we=0.
- Read return: registered rd_owner records the issuer (CPU or VID) of each read.
  - Next cycle, VID → vid_rvalid=1, vid_rdata=ram_rdata.
  - Next cycle, CPU → handled by RD_WAIT.
- Pipelining: a video read may be granted in the CPU's RD_WAIT cycle. Throughput is one access per cycle.
- Starvation counter wait_cnt:
  - Increments when vid_req && !vid_gnt; saturates at MAX_WAIT.
  - Clears on vid_gnt, and when vid_req drops.
- Simultaneous CPU write and video read with wait_cnt<MAX_WAIT: CPU write wins; the video wait grows.
- Requester dropping req before grant: legal, no side effects.
- cpu_stall is combinational: cpu_req && !cpu_ack. Read stall is exactly one cycle when uncontended.

Optional Feature:
- Macro RAM_ARBITER_STATS_EN.
- Defined: adds outputs stat_cpu_stall_cnt[31:0] (cycles with cpu_stall=1) and stat_vid_override_cnt[15:0] (video grants forced by wait_cnt>=MAX_WAIT).
  - Both wrap on overflow and clear on reset.
- Undefined: ports and counters absent; arbitration identical.

Decomposition:
- Package ram_arbiter_pkg:
  - owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_VID=2'd2;
  - CPU FSM states ST_IDLE, ST_RD_WAIT;
  - default ADDR_W/DATA_W constants.
- Sub-module arb_wait_counter: saturating counter with inc/clr inputs and a sat flag (wait_cnt>=MAX_WAIT). Reusable for future requesters.

Test Plan:
- CPU write, addr 0x0010, data 0xBEEF, no video → ram_we=1 and cpu_ack=1 same cycle, cpu_stall=0. Then CPU read of 0x0010 → stall 1 cycle, then cpu_ack=1, cpu_rdata=0xBEEF.
- Video alone reads 0x4000 (RAM preloaded 0x1234) → vid_gnt at cycle N, vid_rvalid=1 with vid_rdata=0x1234 at N+1.
- CPU back-to-back writes, vid_req held, MAX_WAIT=4 → video denied 4 cycles; 5th cycle vid_gnt=1, cpu_stall=1 that cycle, wait_cnt=0 afterwards.
- CPU read at N, video read pending → video granted in RD_WAIT at N+1. cpu_rdata at N+1 and vid_rdata at N+2 come from the correct addresses (0x0001→0xAAAA, 0x4001→0x5555).
- reset_n asserted during CPU RD_WAIT → cpu_ack, vid_rvalid and ram_we go 0 immediately. After release, no stale ack or rvalid appears.
- RAM_ARBITER_STATS_EN defined, the starvation scenario run twice → stat_vid_override_cnt=2, stat_cpu_stall_cnt equals the number of observed stall cycles.
